// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, streams words from a combinational
// program memory into a small circular buffer, and presents the oldest to IF/ID.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_data_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    input  logic                       deq_i,
    output logic                       valid_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_plus_4_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] pc4_mem_q   [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic        head_valid;
    logic        deq;
    logic        enq;
    logic [31:0] fetch_pc_inc;

    assign head_valid   = (count_q != '0);
    assign deq          = deq_i & head_valid;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign enq          = ~redirect_i & ((count_q != FULL_CNT) | deq);
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_inc;
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: storage is not reset; stale entries are never visible because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc4_mem_q[wr_ptr_q]   <= fetch_pc_inc;
            instr_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

    assign imem_addr_o = fetch_pc_q;
    assign valid_o     = head_valid;
    assign count_o     = count_q;
    assign instr_o     = head_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pc_plus_4_o = head_valid ? pc4_mem_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-based reference model compared
// every cycle, plus directed literal checks from the hand-worked scenarios.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        deq_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_plus_4_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .deq_i         (deq_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_plus_4_o   (pc_plus_4_o),
        .count_o       (count_o)
    );

    always #5 clk = ~clk;

    // Program memory: word index counted from RESET_PC.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        return 32'h1000_0000 + ((addr - RESET_PC) >> 2);
    endfunction

    assign imem_data_i = rom(imem_addr_o);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {pc+4, instr} and a fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          model_ok = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_pc     = RESET_PC;
            model_ok = 1;
        end else if (model_ok) begin
            if (redirect_i) begin
                mq.delete();
                m_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else begin
                bit can_take;
                bit pop;
                pop      = deq_i && (mq.size() > 0);
                can_take = (mq.size() < DEPTH) || pop;
                if (pop) void'(mq.pop_front());
                if (can_take) begin
                    mq.push_back({m_pc + 32'd4, rom(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [63:0] head;
            head = (mq.size() > 0) ? mq[0] : 64'h0;
            check("m_addr",  imem_addr_o, m_pc);
            check("m_valid", 32'(valid_o), 32'(mq.size() > 0));
            check("m_count", 32'(count_o), mq.size());
            check("m_instr", instr_o, head[31:0]);
            check("m_pc4",   pc_plus_4_o, head[63:32]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rd, input logic [31:0] rpc, input logic dq);
        reset         = rst;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        deq_i         = dq;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_addr",  imem_addr_o, RESET_PC);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc4",   pc_plus_4_o, 32'h0);
        check("rst_count", 32'(count_o), 32'd0);

        // Streaming with deq held high.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("s1_instr", instr_o, 32'h1000_0000);
        check("s1_pc4",   pc_plus_4_o, 32'h0040_0004);
        tick();
        check("s2_instr", instr_o, 32'h1000_0001);
        check("s2_pc4",   pc_plus_4_o, 32'h0040_0008);
        check("s2_count", 32'(count_o), 32'd1);
        for (int i = 0; i < 5; i++) tick();

        // Stall fill, then release.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("fill_count", 32'(count_o), 32'd4);
        check("fill_addr",  imem_addr_o, 32'h0040_0010);
        check("fill_instr", instr_o, 32'h1000_0000);
        deq_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("rel_instr", instr_o, 32'h1000_0000 + i);
            if (i == 1) check("full_deq_count", 32'(count_o), 32'd4);
        end

        // Alternating consumer; the model checks ordering every cycle.
        for (int i = 0; i < 20; i++) begin
            deq_i = i[0];
            tick();
        end

        // Redirect with three entries buffered.
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        check("pre_rd_count", 32'(count_o), 32'd3);
        drive(1'b0, 1'b1, 32'h0040_0103, 1'b1);
        tick();
        check("rd1_valid", 32'(valid_o), 32'd0);
        check("rd1_addr",  imem_addr_o, 32'h0040_0100);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("rd2_valid", 32'(valid_o), 32'd1);
        check("rd2_instr", instr_o, 32'h1000_0040);
        check("rd2_pc4",   pc_plus_4_o, 32'h0040_0104);

        // Reset wins over a concurrent redirect.
        tick();
        check("pre_rst_count", 32'(count_o), 32'd2);
        drive(1'b1, 1'b1, 32'h0000_1234, 1'b1);
        tick();
        check("mrst_addr",  imem_addr_o, RESET_PC);
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_count", 32'(count_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("restart_instr", instr_o, 32'h1000_0000);

        // Address wrap, with deq held high through the empty cycle.
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("wrap_count", 32'(count_o), 32'd1);
        check("wrap_pc4_a", pc_plus_4_o, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc4_b", pc_plus_4_o, 32'h0000_0000);
        tick();
        check("wrap_pc4_c", pc_plus_4_o, 32'h0000_0004);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
